// File: rtl/dpram64_arb_pkg.sv
// Shared constants and request record for the dual-requester dpram64 arbiter.
package dpram64_arb_pkg;
  localparam int NREQ       = 2;
  localparam int WORD_BYTES = 8;
  localparam int WORD_SHIFT = 3;
  localparam int MAX_AW     = 32;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  // Address is carried at full width; the top zero-extends its AW-bit address into it.
  typedef struct packed {
    logic [WORD_BYTES-1:0]   we;
    logic [MAX_AW-1:0]       addr;
    logic [8*WORD_BYTES-1:0] wdata;
  } req_t;
endpackage

// File: rtl/dpram64_arb_if.sv
// Requester-side request/response bus of dpram64_arb, one lane per requester.
// Handshake: a request transfers in a cycle where req_valid[r] & req_ready[r]; while
// req_valid[r] & !req_ready[r] the requester holds all req_* stable; rsp_valid[r] pulses
// exactly one cycle after the transfer and cannot be back-pressured.
interface dpram64_arb_if #(parameter int AW = 16);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][7:0]    req_we;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][63:0]   req_wdata;
  logic [1:0]         rsp_valid;
  logic [1:0][63:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dpram64_arb_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips only when both request and ce is high.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       ce,
  output logic [1:0] gnt
);
  logic prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) prio <= 1'b0;
    else if (ce && (req == 2'b11)) prio <= ~prio;
  end
endmodule

// File: rtl/dpram64_arb.sv
// Grants at most one read and one write per cycle to a shared dpram64, with per-port
// round-robin and a same-word read deferral so the read observes the fresh write.
module dpram64_arb
  import dpram64_arb_pkg::*;
#(
  parameter int SIZE = 65536,
  localparam int AW  = $clog2(SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  dpram64_arb_if.slave        bus,
  output logic [7:0]          ram_we,
  output logic [63:0]         ram_din,
  output logic [AW-1:0]       ram_waddr,
  output logic [AW-1:0]       ram_raddr,
  input  logic [63:0]         ram_dout
);
  req_t       reqs [NREQ];
  logic [1:0] rd_req, wr_req, rd_gnt_raw, rd_gnt, wr_gnt;
  logic       rd_idx, wr_idx, collision;
  logic [1:0] rsp_pend, rsp_isrd;
  logic [AW-1:0] waddr_q, raddr_q;
  logic [63:0]   din_q;

  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      reqs[r]       = '0;
      reqs[r].we    = bus.req_we[r];
      reqs[r].addr  = MAX_AW'(bus.req_addr[r]);
      reqs[r].wdata = bus.req_wdata[r];
      rd_req[r] = bus.req_valid[r] & ~rst & ((bus.req_we[r] == 8'h00) ? ~RD : RD);
      wr_req[r] = bus.req_valid[r] & ~rst & ((bus.req_we[r] != 8'h00) ? WR : ~WR);
    end
  end

  rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(wr_req), .ce(1'b1),       .gnt(wr_gnt));
  rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(rd_req), .ce(~collision), .gnt(rd_gnt_raw));

  // The read and write winners are always different requesters, so compare their word addresses.
  assign rd_idx    = rd_gnt_raw[1];
  assign wr_idx    = wr_gnt[1];
  assign collision = (|rd_gnt_raw) && (|wr_gnt) &&
                     (reqs[rd_idx].addr[AW-1:WORD_SHIFT] == reqs[wr_idx].addr[AW-1:WORD_SHIFT]);
  assign rd_gnt    = collision ? 2'b00 : rd_gnt_raw;

  assign bus.req_ready = rd_gnt | wr_gnt;

  assign ram_we    = (|wr_gnt) ? reqs[wr_idx].we              : 8'h00;
  assign ram_din   = (|wr_gnt) ? reqs[wr_idx].wdata           : din_q;
  assign ram_waddr = (|wr_gnt) ? reqs[wr_idx].addr[AW-1:0]    : waddr_q;
  assign ram_raddr = (|rd_gnt) ? reqs[rd_idx].addr[AW-1:0]    : raddr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend <= 2'b00;
      rsp_isrd <= 2'b00;
      waddr_q  <= '0;
      raddr_q  <= '0;
      din_q    <= '0;
    end else begin
      rsp_pend <= bus.req_ready;
      rsp_isrd <= rd_gnt;
      waddr_q  <= ram_waddr;
      raddr_q  <= ram_raddr;
      din_q    <= ram_din;
    end
  end

  // Masking with rst drops a response that was pending when reset arrived.
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      bus.rsp_valid[r] = rsp_pend[r] & ~rst;
      bus.rsp_rdata[r] = (bus.rsp_valid[r] & rsp_isrd[r]) ? ram_dout : 64'h0;
    end
  end
endmodule

// File: tb/tb_dpram64_arb.sv
// Directed bench for dpram64_arb with a behavioural dpram64 (registered read) behind it.
module tb_dpram64_arb;
  localparam int SIZE = 65536;
  localparam int AW   = $clog2(SIZE);

  localparam logic [63:0] D1  = 64'h1122334455667788;
  localparam logic [63:0] D2  = 64'h11223344556677AA;
  localparam logic [63:0] DA  = 64'hA0A0A0A0A0A0A0A0;
  localparam logic [63:0] DB  = 64'hB1B1B1B1B1B1B1B1;
  localparam logic [63:0] DED = 64'h000000000000DEAD;

  logic clk = 1'b0;
  logic rst;
  logic [7:0]    ram_we;
  logic [63:0]   ram_din;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [63:0]   ram_dout = 64'h0;
  logic [63:0]   mem [0:SIZE/8-1] = '{default: 64'h0};

  int n_vec = 0;
  int n_err = 0;

  dpram64_arb_if #(.AW(AW)) bus ();

  dpram64_arb #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_we(ram_we), .ram_din(ram_din), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // dpram64 model: byte-enable write, registered read returning pre-write contents.
  always @(posedge clk) begin
    for (int b = 0; b < 8; b++)
      if (ram_we[b]) mem[ram_waddr[AW-1:3]][b*8 +: 8] <= ram_din[b*8 +: 8];
    ram_dout <= mem[ram_raddr[AW-1:3]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] we,
                         input logic [AW-1:0] addr, input logic [63:0] d);
    bus.req_valid[r] = v;
    bus.req_we[r]    = we;
    bus.req_addr[r]  = addr;
    bus.req_wdata[r] = d;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int g0, g1;
    logic [1:0] exp_gnt, prev_gnt;
    g0 = 0;
    g1 = 0;
    prev_gnt = 2'b00;
    rst = 1'b1;
    set_req(0, 1'b1, 8'hFF, AW'(16'h0010), D1);
    set_req(1, 1'b0, 8'h00, '0, 64'h0);

    // Reset holds off grants even with a request pending
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_ram_we", 64'(ram_we), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_rdata0", bus.rsp_rdata[0], 64'h0);
    tick();
    rst = 1'b0;

    // 1: full write then read of 0x10
    @(negedge clk);
    chk("t1_wr_ready", 64'(bus.req_ready), 64'h1);
    chk("t1_ram_we", 64'(ram_we), 64'hFF);
    chk("t1_ram_waddr", 64'(ram_waddr), 64'h10);
    chk("t1_ram_din", ram_din, D1);
    tick();
    set_req(0, 1'b1, 8'h00, AW'(16'h0010), 64'h0);
    @(negedge clk);
    chk("t1_wack_valid", 64'(bus.rsp_valid), 64'h1);
    chk("t1_wack_rdata", bus.rsp_rdata[0], 64'h0);
    chk("t1_rd_ready", 64'(bus.req_ready), 64'h1);
    chk("t1_ram_raddr", 64'(ram_raddr), 64'h10);
    tick();

    // 2: byte-enable write from r1 merges into word 0x10
    set_req(0, 1'b0, 8'h00, '0, 64'h0);
    set_req(1, 1'b1, 8'h01, AW'(16'h0010), 64'h00000000000000AA);
    @(negedge clk);
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("t1_rdata", bus.rsp_rdata[0], D1);
    chk("t2_wr_ready", 64'(bus.req_ready), 64'h2);
    chk("t2_ram_we", 64'(ram_we), 64'h01);
    tick();
    set_req(1, 1'b0, 8'h00, '0, 64'h0);
    set_req(0, 1'b1, 8'h00, AW'(16'h0010), 64'h0);
    @(negedge clk);
    chk("t2_wack_valid", 64'(bus.rsp_valid), 64'h2);
    chk("t2_wack_rdata", bus.rsp_rdata[1], 64'h0);
    chk("t2_rd_ready", 64'(bus.req_ready), 64'h1);
    tick();
    set_req(0, 1'b0, 8'h00, '0, 64'h0);
    @(negedge clk);
    chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("t2_rdata", bus.rsp_rdata[0], D2);
    tick();

    // Contested writes: r0 wins first, r1 follows next cycle
    set_req(0, 1'b1, 8'hFF, AW'(16'h0000), DA);
    set_req(1, 1'b1, 8'hFF, AW'(16'h0008), DB);
    @(negedge clk);
    chk("cw_ready0", 64'(bus.req_ready), 64'h1);
    chk("cw_waddr0", 64'(ram_waddr), 64'h0);
    tick();
    set_req(0, 1'b0, 8'h00, '0, 64'h0);
    @(negedge clk);
    chk("cw_ready1", 64'(bus.req_ready), 64'h2);
    chk("cw_waddr1", 64'(ram_waddr), 64'h8);
    chk("cw_rsp0", 64'(bus.rsp_valid), 64'h1);
    tick();
    set_req(1, 1'b0, 8'h00, '0, 64'h0);
    @(negedge clk);
    chk("cw_rsp1", 64'(bus.rsp_valid), 64'h2);
    tick();

    // 3: continuous contested reads alternate r0, r1, ...
    set_req(0, 1'b1, 8'h00, AW'(16'h0000), 64'h0);
    set_req(1, 1'b1, 8'h00, AW'(16'h0008), 64'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("t3_ready_%0d", i), 64'(bus.req_ready), 64'(exp_gnt));
      if (bus.req_ready[0]) g0++;
      if (bus.req_ready[1]) g1++;
      if (i > 0) begin
        chk($sformatf("t3_rsp_%0d", i), 64'(bus.rsp_valid), 64'(prev_gnt));
        if (prev_gnt[0]) chk($sformatf("t3_rdata0_%0d", i), bus.rsp_rdata[0], DA);
        else             chk($sformatf("t3_rdata1_%0d", i), bus.rsp_rdata[1], DB);
      end
      prev_gnt = exp_gnt;
      tick();
    end
    set_req(0, 1'b0, 8'h00, '0, 64'h0);
    set_req(1, 1'b0, 8'h00, '0, 64'h0);
    @(negedge clk);
    chk("t3_last_rsp", 64'(bus.rsp_valid), 64'h2);
    chk("t3_last_rdata", bus.rsp_rdata[1], DB);
    chk("t3_grants_r0", 64'(g0), 64'd8);
    chk("t3_grants_r1", 64'(g1), 64'd8);
    tick();

    // 4: read and write from different requesters in one cycle
    set_req(0, 1'b1, 8'h00, AW'(16'h0020), 64'h0);
    set_req(1, 1'b1, 8'hFF, AW'(16'h0028), 64'h5555AAAA5555AAAA);
    @(negedge clk);
    chk("t4_ready", 64'(bus.req_ready), 64'h3);
    chk("t4_ram_we", 64'(ram_we), 64'hFF);
    chk("t4_raddr", 64'(ram_raddr), 64'h20);
    chk("t4_waddr", 64'(ram_waddr), 64'h28);
    tick();
    set_req(0, 1'b0, 8'h00, '0, 64'h0);
    set_req(1, 1'b0, 8'h00, '0, 64'h0);
    @(negedge clk);
    chk("t4_rsp", 64'(bus.rsp_valid), 64'h3);
    chk("t4_rdata0", bus.rsp_rdata[0], 64'h0);
    chk("t4_rdata1", bus.rsp_rdata[1], 64'h0);
    tick();

    // 5: same-word collision defers the read, which then sees the new data
    set_req(0, 1'b1, 8'h00, AW'(16'h0030), 64'h0);
    set_req(1, 1'b1, 8'hFF, AW'(16'h0030), DED);
    @(negedge clk);
    chk("t5_ready", 64'(bus.req_ready), 64'h2);
    tick();
    set_req(1, 1'b0, 8'h00, '0, 64'h0);
    @(negedge clk);
    chk("t5_retry_ready", 64'(bus.req_ready), 64'h1);
    chk("t5_wack", 64'(bus.rsp_valid), 64'h2);
    tick();
    set_req(0, 1'b0, 8'h00, '0, 64'h0);
    @(negedge clk);
    chk("t5_rsp", 64'(bus.rsp_valid), 64'h1);
    chk("t5_rdata", bus.rsp_rdata[0], DED);
    tick();

    // 6: move rd_prio to r1, grant a read, then reset before its response
    set_req(0, 1'b1, 8'h00, AW'(16'h0000), 64'h0);
    set_req(1, 1'b1, 8'h00, AW'(16'h0008), 64'h0);
    @(negedge clk);
    chk("t6_pre_ready", 64'(bus.req_ready), 64'h1);
    tick();
    set_req(1, 1'b0, 8'h00, '0, 64'h0);
    @(negedge clk);
    chk("t6_n_ready", 64'(bus.req_ready), 64'h1);
    tick();
    rst = 1'b1;
    set_req(1, 1'b1, 8'hFF, AW'(16'h0048), DB);
    @(negedge clk);
    chk("t6_rst_rsp", 64'(bus.rsp_valid), 64'h0);
    chk("t6_rst_rdata0", bus.rsp_rdata[0], 64'h0);
    chk("t6_rst_ready", 64'(bus.req_ready), 64'h0);
    chk("t6_rst_ram_we", 64'(ram_we), 64'h0);
    tick();
    rst = 1'b0;
    set_req(1, 1'b1, 8'h00, AW'(16'h0008), 64'h0);
    @(negedge clk);
    chk("t6_post_rsp", 64'(bus.rsp_valid), 64'h0);
    chk("t6_rd_prio_r0", 64'(bus.req_ready), 64'h1);
    tick();
    set_req(0, 1'b1, 8'hFF, AW'(16'h0040), DA);
    set_req(1, 1'b1, 8'hFF, AW'(16'h0048), DB);
    @(negedge clk);
    chk("t6_wr_prio_r0", 64'(bus.req_ready), 64'h1);
    chk("t6_rd_rsp", 64'(bus.rsp_valid), 64'h1);
    chk("t6_rd_rdata", bus.rsp_rdata[0], DA);
    tick();
    set_req(0, 1'b0, 8'h00, '0, 64'h0);
    set_req(1, 1'b0, 8'h00, '0, 64'h0);
    @(negedge clk);
    chk("t6_wack_r1_pending", 64'(bus.req_ready), 64'h0);
    chk("t6_wack", 64'(bus.rsp_valid), 64'h1);
    chk("t6_wack_rdata", bus.rsp_rdata[0], 64'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
